// File: rtl/stat_graph_render_pkg.sv
// Shared definitions for the population graph renderer.
//   SCREEN_WIDTH/SCREEN_HEIGHT : raster position that marks the once-per-frame event
//   tally_t                    : sample type at the default 16-bit tally width
//   stat_state_t               : sampling sequencer states
//   GRAPH_MODE_*               : encodings of mode_in
package stat_graph_render_pkg;

    localparam int SCREEN_WIDTH      = 1024;
    localparam int SCREEN_HEIGHT     = 768;
    localparam int TALLY_WIDTH_DEF   = 16;

    typedef logic [TALLY_WIDTH_DEF-1:0] tally_t;

    typedef enum logic [1:0] {ACCUM, WAIT, COMMIT, SCAN} stat_state_t;

    localparam logic GRAPH_MODE_LINE = 1'b0;
    localparam logic GRAPH_MODE_BAR  = 1'b1;

endpackage

// File: rtl/stat_graph_render_history_buf.sv
// Circular sample history with one write and one synchronous read port, plus the
// max/scale engine that walks the filled entries after every commit.
//   clk_in, rst_in : clock, async active-high reset
//   i_wr_en/i_wr_data : commit one sample at the write pointer
//   i_scan_act     : sequencer is in SCAN; the read port belongs to the engine
//   i_scan_step    : engine advances this cycle (low while paused)
//   i_k            : render sample index of the NEXT pixel (read is one cycle ahead)
//   o_rd_data      : registered read data
//   o_fill         : number of valid samples (saturates at HISTORY_LEN)
//   o_scan_done    : pulse in the cycle the scale register is loaded
//   o_scale        : current right-shift for displayed samples
module stat_history_buf
    import stat_graph_render_pkg::*;
#(
    parameter int HISTORY_LEN  = 32,
    parameter int TALLY_WIDTH  = 16,
    parameter int GRAPH_HEIGHT = 128
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         i_wr_en,
    input  logic [TALLY_WIDTH-1:0]       i_wr_data,
    input  logic                         i_scan_act,
    input  logic                         i_scan_step,
    input  logic [10:0]                  i_k,
    output logic [TALLY_WIDTH-1:0]       o_rd_data,
    output logic [$clog2(HISTORY_LEN):0] o_fill,
    output logic                         o_scan_done,
    output logic [4:0]                   o_scale
);
    localparam int PW = $clog2(HISTORY_LEN);

    logic [TALLY_WIDTH-1:0] r_mem [HISTORY_LEN];
    logic [TALLY_WIDTH-1:0] r_rd, r_max, w_max_fin;
    logic [PW-1:0]          r_wr_ptr, w_rd_addr;
    logic [PW:0]            r_fill, r_sc;
    logic [4:0]             r_scale, w_scale;
    int                     w_base, w_sum, w_sidx;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_fill   <= '0;
        end else if (i_wr_en) begin
            r_wr_ptr <= (r_wr_ptr == PW'(HISTORY_LEN-1)) ? '0 : r_wr_ptr + 1'b1;
            if (r_fill != (PW+1)'(HISTORY_LEN))
                r_fill <= r_fill + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (i_wr_en)
            r_mem[r_wr_ptr] <= i_wr_data;
        r_rd <= r_mem[w_rd_addr];
    end

    // Render: oldest sample sits at (wr_ptr - fill) mod N. Scan: while stalled the
    // engine re-reads the previous entry so r_rd always holds entry r_sc-1.
    always_comb begin
        w_base = int'(r_wr_ptr) - int'(r_fill);
        if (w_base < 0) w_base = w_base + HISTORY_LEN;
        w_sum = w_base + int'(i_k);
        if (w_sum >= HISTORY_LEN) w_sum = w_sum - HISTORY_LEN;
        if (int'(i_k) >= HISTORY_LEN) w_sum = 0;
        w_sidx = i_scan_step ? int'(r_sc) : int'(r_sc) - 1;
        if (w_sidx < 0 || w_sidx >= HISTORY_LEN) w_sidx = 0;
        w_rd_addr = i_scan_act ? PW'(w_sidx) : PW'(w_sum);
    end

    assign w_max_fin   = (r_sc != '0 && r_rd > r_max) ? r_rd : r_max;
    assign o_scan_done = i_scan_step && (r_sc == r_fill);

    // Smallest shift that brings the max under the plot height.
    always_comb begin
        w_scale = 5'(TALLY_WIDTH);
        for (int s = TALLY_WIDTH; s >= 0; s--)
            if (int'(w_max_fin >> s) <= GRAPH_HEIGHT - 1)
                w_scale = 5'(s);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_sc    <= '0;
            r_max   <= '0;
            r_scale <= '0;
        end else if (i_wr_en) begin
            r_sc  <= '0;
            r_max <= '0;
        end else if (i_scan_step) begin
            r_max <= w_max_fin;
            if (r_sc == r_fill) begin
                r_sc    <= '0;
                r_scale <= w_scale;
            end else begin
                r_sc <= r_sc + 1'b1;
            end
        end
    end

    assign o_rd_data = r_rd;
    assign o_fill    = r_fill;
    assign o_scale   = r_scale;

endmodule

// File: rtl/stat_graph_render.sv
// Population graph: counts alive cells per frame, keeps a circular history and
// renders axes plus a line or bar trace with an auto-ranging vertical scale.
//   clk_in, rst_in         : pixel clock, async active-high reset
//   hcount_in, vcount_in   : raster position
//   is_alive_in/count_en_in: one qualified cell per count_en_in pulse
//   mode_in                : 0 line, 1 filled bars
//   pause_in               : freeze sampling; rendering continues
//   pix_out                : registered graph pixel (1 cycle latency)
//   scale_out              : current sample right-shift
module stat_graph_render
    import stat_graph_render_pkg::*;
#(
    parameter int          ORIGIN_X      = 800,
    parameter int          ORIGIN_Y      = 16,
    parameter int          GRAPH_WIDTH   = 256,
    parameter int          GRAPH_HEIGHT  = 128,
    parameter int          HISTORY_LEN   = 32,
    parameter int          SAMPLE_PERIOD = 32,
    parameter int          TALLY_WIDTH   = 16,
    parameter logic [11:0] TRACE_COLOR   = 12'h0F0,
    parameter logic [11:0] AXIS_COLOR    = 12'hFFF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        is_alive_in,
    input  logic        count_en_in,
    input  logic        mode_in,
    input  logic        pause_in,
    output logic [11:0] pix_out,
    output logic [4:0]  scale_out
);
    localparam int PIX_PER = GRAPH_WIDTH / HISTORY_LEN;
    localparam int CW      = (PIX_PER > 1) ? $clog2(PIX_PER) : 1;
    localparam int FW      = $clog2(SAMPLE_PERIOD + 1);
    localparam int PW      = $clog2(HISTORY_LEN);
    localparam int YB      = ORIGIN_Y + GRAPH_HEIGHT;

    stat_state_t            r_state, w_state_nxt;
    logic [TALLY_WIDTH-1:0] r_acc, w_rd, w_h;
    logic [FW-1:0]          r_frame;
    logic [CW-1:0]          r_col, w_col_nxt;
    logic [10:0]            r_k, w_k_nxt;
    logic [PW:0]            w_fill;
    logic [11:0]            r_pix, w_pix;
    logic                   w_evt, w_wr_en, w_acc_clr, w_frame_ld, w_frame_inc;
    logic                   w_scan_done, w_hit;
    int                     w_top, w_v, w_hc;

    assign w_evt = !pause_in && (hcount_in == 11'(SCREEN_WIDTH))
                             && (vcount_in == 10'(SCREEN_HEIGHT));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= ACCUM;
        else        r_state <= w_state_nxt;
    end

    // Pause freezes every transition, including COMMIT and a partial SCAN.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_acc_clr   = 1'b0;
        w_frame_ld  = 1'b0;
        w_frame_inc = 1'b0;
        case (r_state)
            ACCUM:  if (w_evt) w_state_nxt = COMMIT;
            COMMIT: if (!pause_in) begin
                w_wr_en     = 1'b1;
                w_state_nxt = SCAN;
            end
            SCAN:   if (w_scan_done) begin
                if (SAMPLE_PERIOD == 1) begin
                    w_state_nxt = ACCUM;
                    w_acc_clr   = 1'b1;
                end else begin
                    w_state_nxt = WAIT;
                    w_frame_ld  = 1'b1;
                end
            end
            WAIT:   if (w_evt) begin
                if (r_frame == FW'(SAMPLE_PERIOD - 1)) begin
                    w_state_nxt = ACCUM;
                    w_acc_clr   = 1'b1;
                end else begin
                    w_frame_inc = 1'b1;
                end
            end
            default: w_state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_acc   <= '0;
            r_frame <= '0;
        end else begin
            if (w_acc_clr)
                r_acc <= '0;
            else if (r_state == ACCUM && !pause_in && count_en_in && is_alive_in && r_acc != '1)
                r_acc <= r_acc + 1'b1;
            if (w_frame_ld)
                r_frame <= FW'(1);
            else if (w_frame_inc)
                r_frame <= r_frame + 1'b1;
        end
    end

    stat_history_buf #(
        .HISTORY_LEN (HISTORY_LEN),
        .TALLY_WIDTH (TALLY_WIDTH),
        .GRAPH_HEIGHT(GRAPH_HEIGHT)
    ) u_hist (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .i_wr_en    (w_wr_en),
        .i_wr_data  (r_acc),
        .i_scan_act (r_state == SCAN),
        .i_scan_step(r_state == SCAN && !pause_in),
        .i_k        (w_k_nxt),
        .o_rd_data  (w_rd),
        .o_fill     (w_fill),
        .o_scan_done(w_scan_done),
        .o_scale    (scale_out)
    );

    // r_col/r_k describe the pixel at hcount_in; their next values address the
    // history so the read data lands in the same cycle as its pixel. Loading
    // zero while hcount_in==ORIGIN_X makes column 0 / sample 0 start at ORIGIN_X+1.
    always_comb begin
        w_col_nxt = r_col + 1'b1;
        w_k_nxt   = r_k;
        if (hcount_in == 11'(ORIGIN_X)) begin
            w_col_nxt = '0;
            w_k_nxt   = '0;
        end else if (r_col == CW'(PIX_PER - 1)) begin
            w_col_nxt = '0;
            if (r_k != '1) w_k_nxt = r_k + 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_col <= '0;
            r_k   <= '0;
        end else begin
            r_col <= w_col_nxt;
            r_k   <= w_k_nxt;
        end
    end

    assign w_h   = w_rd >> scale_out;
    assign w_top = YB - 1 - int'(w_h);
    assign w_v   = int'(vcount_in);
    assign w_hc  = int'(hcount_in);

    always_comb begin
        case (mode_in)
            GRAPH_MODE_LINE: w_hit = (w_v == w_top);
            GRAPH_MODE_BAR:  w_hit = (w_v >= w_top) && (w_v <= YB - 1);
        endcase
        w_pix = '0;
        if ((w_v == YB && w_hc >= ORIGIN_X && w_hc <= ORIGIN_X + GRAPH_WIDTH) ||
            (w_hc == ORIGIN_X && w_v >= ORIGIN_Y && w_v <= YB))
            w_pix = AXIS_COLOR;
        else if (w_hc > ORIGIN_X && w_hc <= ORIGIN_X + GRAPH_WIDTH &&
                 int'(r_k) < int'(w_fill) && w_hit)
            w_pix = TRACE_COLOR;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_pix <= '0;
        else        r_pix <= w_pix;
    end

    assign pix_out = r_pix;

endmodule

// File: tb/tb_stat_graph_render.sv
module tb_stat_graph_render;
    import stat_graph_render_pkg::*;

    localparam int OX = 800, OY = 16, GW = 64, GH = 64, HL = 4, SP = 1, TW = 8;
    localparam int YB = OY + GH;
    localparam int SW = SCREEN_WIDTH, SH = SCREEN_HEIGHT;
    localparam logic [11:0] TR = 12'h0F0, AX = 12'hFFF;

    logic        clk_in = 1'b0, rst_in = 1'b1;
    logic [10:0] hcount_in = '0;
    logic [9:0]  vcount_in = '0;
    logic        is_alive_in = 1'b0, count_en_in = 1'b0, mode_in = 1'b0, pause_in = 1'b0;
    logic [11:0] pix_out;
    logic [4:0]  scale_out;

    always #5 clk_in = ~clk_in;

    stat_graph_render #(
        .ORIGIN_X(OX), .ORIGIN_Y(OY), .GRAPH_WIDTH(GW), .GRAPH_HEIGHT(GH),
        .HISTORY_LEN(HL), .SAMPLE_PERIOD(SP), .TALLY_WIDTH(TW)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .is_alive_in(is_alive_in), .count_en_in(count_en_in), .mode_in(mode_in),
        .pause_in(pause_in), .pix_out(pix_out), .scale_out(scale_out)
    );

    typedef struct {
        logic [11:0] pix;
        logic [4:0]  sc;
        string       name;
    } exp_t;

    exp_t q[$];
    logic chk_req = 1'b0;
    int   n_vec = 0, n_miss = 0;

    // Monitor: a vector flagged in a cycle is sampled just after that cycle's edge.
    always @(posedge clk_in) begin : mon
        exp_t e;
        if (chk_req) begin
            #1;
            n_vec++;
            if (q.size() == 0) begin
                n_miss++;
                $display("FAIL scoreboard_empty: output pix=%h scale=%0d with no expectation", pix_out, scale_out);
            end else begin
                e = q.pop_front();
                if (pix_out !== e.pix || scale_out !== e.sc) begin
                    n_miss++;
                    $display("FAIL %s: got pix=%h scale=%0d, expected pix=%h scale=%0d",
                             e.name, pix_out, scale_out, e.pix, e.sc);
                end
            end
        end
    end

    task automatic drv(input int h, input int v, input bit alive, input bit en);
        @(negedge clk_in);
        chk_req     = 1'b0;
        hcount_in   = 11'(h);
        vcount_in   = 10'(v);
        is_alive_in = alive;
        count_en_in = en;
    endtask

    task automatic chk(input int h, input int v, input logic [11:0] pix,
                       input logic [4:0] sc, input string name);
        exp_t e;
        @(negedge clk_in);
        hcount_in   = 11'(h);
        vcount_in   = 10'(v);
        is_alive_in = 1'b0;
        count_en_in = 1'b0;
        e.pix = pix; e.sc = sc; e.name = name;
        q.push_back(e);
        chk_req = 1'b1;
    endtask

    // Walk one row from the y axis so the render counters line up, then check hstop.
    task automatic sweep(input int v, input int hstop, input logic [11:0] pix,
                         input logic [4:0] sc, input string name);
        for (int h = OX; h < hstop; h++) drv(h, v, 1'b0, 1'b0);
        chk(hstop, v, pix, sc, name);
    endtask

    // One sample: n qualified cells plus unqualified noise, frame event, then the
    // scale is checked every cycle until one cycle past SCAN completion.
    task automatic frame(input int n, input logic [4:0] sc_old, input logic [4:0] sc_new,
                         input int fill_after, input string name);
        for (int i = 0; i < n; i++) drv(0, 0, 1'b1, 1'b1);
        repeat (3) drv(0, 0, 1'b1, 1'b0);
        repeat (3) drv(0, 0, 1'b0, 1'b1);
        drv(SW, SH, 1'b0, 1'b0);
        for (int i = 0; i <= fill_after; i++) chk(0, SH + 1, 12'h000, sc_old, {name, "_scale_old"});
        chk(0, SH + 1, 12'h000, sc_new, {name, "_scale_new"});
        repeat (3) drv(0, SH + 1, 1'b0, 1'b0);
    endtask

    initial begin
        chk(OX, YB, 12'h000, 5'd0, "rst_pix");
        drv(0, 0, 1'b0, 1'b0);
        rst_in = 1'b0;

        chk(OX, 50, AX, 5'd0, "yaxis");
        chk(OX + 10, YB, AX, 5'd0, "xaxis");
        chk(OX + GW, YB, AX, 5'd0, "xaxis_end");
        chk(OX + GW + 1, YB, 12'h000, 5'd0, "xaxis_past");
        chk(OX, OY - 1, 12'h000, 5'd0, "yaxis_above");
        sweep(29, OX + 5, 12'h000, 5'd0, "empty_hist");

        // 50 cells, scale 0 -> line at OY+13
        frame(50, 5'd0, 5'd0, 1, "s1");
        sweep(OY + 13, OX + 1, TR, 5'd0, "s1_first_col");
        sweep(OY + 13, OX + 16, TR, 5'd0, "s1_last_col");
        sweep(OY + 13, OX + 17, 12'h000, 5'd0, "s1_unfilled");
        sweep(OY + 12, OX + 5, 12'h000, 5'd0, "s1_row_above");

        // 200 cells -> scale 2, taking effect only as SCAN completes
        frame(200, 5'd0, 5'd2, 2, "s2");
        sweep(OY + 13, OX + 17, TR, 5'd2, "s2_line");
        sweep(67, OX + 8, TR, 5'd2, "s1_rescaled");
        sweep(OY + 13, OX + 1, 12'h000, 5'd2, "s1_moved");

        frame(30, 5'd2, 5'd2, 3, "s3");
        frame(40, 5'd2, 5'd2, 4, "s4");
        frame(300, 5'd2, 5'd2, 4, "s5_sat");
        // history now oldest..newest = 200, 30, 40, 255
        sweep(OY, OX + 49, TR, 5'd2, "sat_first");
        sweep(OY, OX + 64, TR, 5'd2, "sat_last");
        sweep(29, OX + 16, TR, 5'd2, "oldest_200");
        sweep(29, OX + 17, 12'h000, 5'd2, "k1_not200");
        sweep(72, OX + 17, TR, 5'd2, "k1_30");
        sweep(69, OX + 33, TR, 5'd2, "k2_40");

        mode_in = 1'b1;
        sweep(72, OX + 20, TR, 5'd2, "bar_top");
        sweep(YB - 1, OX + 20, TR, 5'd2, "bar_base");
        sweep(71, OX + 20, 12'h000, 5'd2, "bar_above");
        sweep(YB, OX + 20, AX, 5'd2, "bar_axis");
        mode_in = 1'b0;
        sweep(75, OX + 20, 12'h000, 5'd2, "line_gap");

        pause_in = 1'b1;
        repeat (3) begin
            for (int i = 0; i < 20; i++) drv(0, 0, 1'b1, 1'b1);
            drv(SW, SH, 1'b0, 1'b0);
            repeat (3) chk(0, SH + 1, 12'h000, 5'd2, "pause_hold");
        end
        pause_in = 1'b0;
        sweep(29, OX + 1, TR, 5'd2, "pause_hist");

        // acc must still be 0: history becomes 30, 40, 255, 0
        frame(0, 5'd2, 5'd2, 4, "s6_zero");
        sweep(YB - 1, OX + 60, TR, 5'd2, "acc_zero");
        sweep(72, OX + 1, TR, 5'd2, "shift_k0");

        for (int i = 0; i < 10; i++) drv(0, 0, 1'b1, 1'b1);
        drv(SW, SH, 1'b0, 1'b0);
        drv(0, SH + 1, 1'b0, 1'b0);
        drv(0, SH + 1, 1'b0, 1'b0);
        chk(OX, 50, 12'h000, 5'd0, "rst_midscan");
        rst_in = 1'b1;
        drv(0, SH + 1, 1'b0, 1'b0);
        rst_in = 1'b0;
        chk(OX, 50, AX, 5'd0, "post_rst_axis");
        sweep(YB - 1, OX + 60, 12'h000, 5'd0, "post_rst_empty");
        sweep(OY, OX + 49, 12'h000, 5'd0, "post_rst_empty2");

        drv(0, 0, 1'b0, 1'b0);
        repeat (3) @(posedge clk_in);
        #2;
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
